// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit hold / shift-right / shift-left / load
// register with a modulo-2^CNT_W shift counter, a wrap pulse and serial taps.
// Optional build macro: USR_ROTATE_EN. When it is defined, rot=1 turns both
// shift modes into rotates. When it is undefined, the rot port is ignored.
// The next state of each bit comes from a tree of 2:1 muxes.
// mode[0] drives the inner stages and mode[1] drives the outer stage.
module universal_shift_register #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cnt_wrap
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Behavioural model of one 2:1 mux cell.
  function automatic logic mux2(input logic sel, input logic in0, input logic in1);
    logic res;
    if (sel) begin
      res = in1;
    end else begin
      res = in0;
    end
    return res;
  endfunction

  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] shift_cnt_r;
  logic             cnt_wrap_r;

  logic [WIDTH-1:0] next_q_s;
  logic [WIDTH-1:0] inner_lo_s;
  logic [WIDTH-1:0] inner_hi_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic             next_wrap_s;
  logic             msb_src_s;
  logic             lsb_src_s;

`ifdef USR_ROTATE_EN
  // A rotate feeds the bit that leaves the far end back in at the edge bit.
  assign msb_src_s = rot ? q_r[0] : sin_r;
  assign lsb_src_s = rot ? q_r[WIDTH-1] : sin_l;
`else
  logic rot_unused_s;
  assign rot_unused_s = rot;
  assign msb_src_s    = sin_r;
  assign lsb_src_s    = sin_l;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_s;
    logic left_s;

    if (i == WIDTH-1) begin : g_msb
      assign right_s = msb_src_s;
    end else begin : g_not_msb
      assign right_s = q_r[i+1];
    end

    if (i == 0) begin : g_lsb
      assign left_s = lsb_src_s;
    end else begin : g_not_lsb
      assign left_s = q_r[i-1];
    end

    // Inner stages: hold/right when mode[1]=0, left/load when mode[1]=1.
    assign inner_lo_s[i] = mux2(mode[0], q_r[i], right_s);
    assign inner_hi_s[i] = mux2(mode[0], left_s, d[i]);
    // Outer stage: choose the half.
    assign next_q_s[i]   = mux2(mode[1], inner_lo_s[i], inner_hi_s[i]);
  end

  // Next counter value and wrap pulse. A load or a hold leaves the pulse low.
  always_comb begin
    next_cnt_s  = shift_cnt_r;
    next_wrap_s = 1'b0;
    case (mode)
      MODE_HOLD: begin
        next_cnt_s  = shift_cnt_r;
        next_wrap_s = 1'b0;
      end
      MODE_RIGHT, MODE_LEFT: begin
        next_cnt_s = shift_cnt_r + CNT_ONE;
        if (shift_cnt_r == CNT_MAX) begin
          next_wrap_s = 1'b1;
        end else begin
          next_wrap_s = 1'b0;
        end
      end
      MODE_LOAD: begin
        next_cnt_s  = CNT_ZERO;
        next_wrap_s = 1'b0;
      end
      default: begin
        next_cnt_s  = shift_cnt_r;
        next_wrap_s = 1'b0;
      end
    endcase
  end

  // State registers. The synchronous reset overrides every mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r         <= {WIDTH{1'b0}};
      shift_cnt_r <= CNT_ZERO;
      cnt_wrap_r  <= 1'b0;
    end else begin
      q_r         <= next_q_s;
      shift_cnt_r <= next_cnt_s;
      cnt_wrap_r  <= next_wrap_s;
    end
  end

  assign q         = q_r;
  assign shift_cnt = shift_cnt_r;
  assign cnt_wrap  = cnt_wrap_r;
  assign so_r      = q_r[0];
  assign so_l      = q_r[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=4, CNT_W=8).
// Rotate vectors are selected by USR_ROTATE_EN.
module tb_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] d;
  logic       sin_r;
  logic       sin_l;
  logic       rot;
  logic [3:0] q;
  logic       so_r;
  logic       so_l;
  logic [7:0] shift_cnt;
  logic       cnt_wrap;

  int n_cmp;
  int n_err;

  universal_shift_register #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .d        (d),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .rot      (rot),
    .q        (q),
    .so_r     (so_r),
    .so_l     (so_l),
    .shift_cnt(shift_cnt),
    .cnt_wrap (cnt_wrap)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 unit before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mode  = 2'b11;
    d     = 4'hF;
    sin_r = 1'b0;
    sin_l = 1'b0;
    rot   = 1'b0;

    // Reset beats load.
    tick();
    tick();
    check("rst_q", 32'(q), 32'h0);
    check("rst_cnt", 32'(shift_cnt), 32'h0);
    check("rst_wrap", 32'(cnt_wrap), 32'h0);

    // Load, then hold.
    rst_n = 1'b1;
    mode  = 2'b11;
    d     = 4'hA;
    tick();
    check("load_q", 32'(q), 32'hA);
    check("load_cnt", 32'(shift_cnt), 32'h0);
    check("load_so_r", 32'(so_r), 32'h0);
    check("load_so_l", 32'(so_l), 32'h1);
    mode = 2'b00;
    d    = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q", 32'(q), 32'hA);
      check("hold_cnt", 32'(shift_cnt), 32'h0);
    end

    // Shift right with sin_r=1: A -> D -> E.
    mode  = 2'b01;
    sin_r = 1'b1;
    tick();
    check("sr1_q", 32'(q), 32'hD);
    check("sr1_so_r", 32'(so_r), 32'h1);
    check("sr1_cnt", 32'(shift_cnt), 32'h1);
    tick();
    check("sr2_q", 32'(q), 32'hE);
    check("sr2_so_r", 32'(so_r), 32'h0);
    check("sr2_cnt", 32'(shift_cnt), 32'h2);

    // Hold keeps a non-zero count.
    mode = 2'b00;
    tick();
    check("hold2_q", 32'(q), 32'hE);
    check("hold2_cnt", 32'(shift_cnt), 32'h2);

    // Load 9, then shift left with sin_l=0: 9 -> 2.
    mode = 2'b11;
    d    = 4'h9;
    tick();
    check("load9_cnt", 32'(shift_cnt), 32'h0);
    mode  = 2'b10;
    sin_l = 1'b0;
    tick();
    check("sl_q", 32'(q), 32'h2);
    check("sl_so_l", 32'(so_l), 32'h0);
    check("sl_cnt", 32'(shift_cnt), 32'h1);

    // Counter wrap after 256 shifts from zero.
    mode = 2'b11;
    d    = 4'h0;
    tick();
    mode  = 2'b01;
    sin_r = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
      check("wrap_nopulse", 32'(cnt_wrap), 32'h0);
    end
    check("wrap_cnt255", 32'(shift_cnt), 32'hFF);
    tick();
    check("wrap_cnt0", 32'(shift_cnt), 32'h0);
    check("wrap_pulse", 32'(cnt_wrap), 32'h1);
    mode = 2'b00;
    tick();
    check("wrap_pulse_end", 32'(cnt_wrap), 32'h0);
    check("wrap_hold_cnt", 32'(shift_cnt), 32'h0);

    // A load on the wrap edge cancels the pulse.
    mode = 2'b10;
    for (int i = 0; i < 255; i++) begin
      tick();
    end
    check("wrap2_cnt255", 32'(shift_cnt), 32'hFF);
    mode = 2'b11;
    d    = 4'h5;
    tick();
    check("wrap2_load_q", 32'(q), 32'h5);
    check("wrap2_load_cnt", 32'(shift_cnt), 32'h0);
    check("wrap2_no_pulse", 32'(cnt_wrap), 32'h0);

    // rst_n pulsed low between edges has no effect.
    @(negedge clk);
    rst_n = 1'b0;
    mode  = 2'b00;
    #2;
    check("idle_rst_q", 32'(q), 32'h5);
    rst_n = 1'b1;
    tick();
    check("idle_rst_q2", 32'(q), 32'h5);

    // Reset in the middle of a shift sequence.
    mode  = 2'b01;
    sin_r = 1'b1;
    tick();
    check("mid_sr_q", 32'(q), 32'hA);
    rst_n = 1'b0;
    tick();
    check("mid_rst_q", 32'(q), 32'h0);
    check("mid_rst_cnt", 32'(shift_cnt), 32'h0);
    rst_n = 1'b1;

    // Rotate request.
    mode = 2'b11;
    d    = 4'h1;
    rot  = 1'b1;
    tick();
    check("rot_load_q", 32'(q), 32'h1);
    mode  = 2'b01;
    sin_r = 1'b0;
`ifdef USR_ROTATE_EN
    tick();
    check("rot_r_q", 32'(q), 32'h8);
    mode  = 2'b10;
    sin_l = 1'b0;
    sin_r = 1'b1;
    tick();
    check("rot_l1_q", 32'(q), 32'h1);
    sin_l = 1'b1;
    sin_r = 1'b0;
    tick();
    check("rot_l2_q", 32'(q), 32'h2);
    check("rot_cnt", 32'(shift_cnt), 32'h3);
`else
    tick();
    check("norot_r_q", 32'(q), 32'h0);
    mode  = 2'b10;
    sin_l = 1'b1;
    tick();
    check("norot_l_q", 32'(q), 32'h1);
    check("norot_cnt", 32'(shift_cnt), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
